// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with atomic RW/RS/RC, trap/MRET sequencing, mip/mie, vectored mtvec and counters.
// Optional macro CSR_HPM_EN adds the mhpmcounter bank, hpm_event_i and mcountinhibit bits 3 and up.
module csr_unit #(
  parameter int XLEN = 32,
  parameter int CNT_W = 64,
  parameter int NUM_HPM = 4,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_csr_valid_i,
  input  logic [1:0]         ex_csr_op_i,
  input  logic [11:0]        ex_csr_addr_i,
  input  logic [XLEN-1:0]    ex_csr_wdata_i,
  output logic [XLEN-1:0]    ex_csr_rdata_o,
  output logic               ex_csr_illegal_o,
  input  logic               instret_i,
  input  logic [NUM_HPM-1:0] hpm_event_i,
  input  logic               trap_take_i,
  input  logic [XLEN-1:0]    trap_cause_i,
  input  logic [XLEN-1:0]    trap_pc_i,
  input  logic               mret_i,
  input  logic               irq_ext_i,
  input  logic               irq_tmr_i,
  input  logic               irq_sw_i,
  output logic               irq_pending_o,
  output logic [XLEN-1:0]    trap_vector_o,
  output logic [XLEN-1:0]    mepc_o,
  output logic               global_irq_en_o
);
  localparam int HW = CNT_W - XLEN;
  logic mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0] mie_q, mie_d, mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [XLEN-1:0] rd_val, wval, inh_rd;
  logic impl, wr_try, we;
`ifdef CSR_HPM_EN
  logic [NUM_HPM-1:0] hpm_inh_q, hpm_inh_d;
  logic [CNT_W-1:0] hpm_q [NUM_HPM];
  logic [CNT_W-1:0] hpm_d [NUM_HPM];
  assign inh_rd = XLEN'({hpm_inh_q, ir_inh_q, 1'b0, cy_inh_q});
`else
  logic unused_hpm;
  assign unused_hpm = ^hpm_event_i;
  assign inh_rd = XLEN'({ir_inh_q, 1'b0, cy_inh_q});
`endif

  function automatic logic [XLEN-1:0] lo_f(input logic [CNT_W-1:0] c);
    return c[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] hi_f(input logic [CNT_W-1:0] c);
    return XLEN'(c[CNT_W-1:XLEN]);
  endfunction

  // A half-write replaces the increment for that cycle; the other half keeps its old value.
  function automatic logic [CNT_W-1:0] cnt_f(input logic [CNT_W-1:0] c, input logic inc,
                                             input logic wl, input logic wh, input logic [XLEN-1:0] v);
    return wh ? {v[HW-1:0], c[XLEN-1:0]} : wl ? {c[CNT_W-1:XLEN], v} : c + CNT_W'(inc);
  endfunction

  function automatic logic ws(input logic [11:0] a);
    return we && ex_csr_addr_i == a;
  endfunction

  always_comb begin
    impl = 1'b1;
    rd_val = '0;
    case (ex_csr_addr_i)
      12'h300: rd_val = XLEN'({2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});
      12'h304: rd_val = XLEN'({mie_q[2], 3'b000, mie_q[1], 3'b000, mie_q[0], 3'b000});
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h344: rd_val = XLEN'({mip_q[2], 3'b000, mip_q[1], 3'b000, mip_q[0], 3'b000});
      12'h320: rd_val = inh_rd;
      12'hB00, 12'hC00: rd_val = lo_f(mcycle_q);
      12'hB80, 12'hC80: rd_val = hi_f(mcycle_q);
      12'hB02, 12'hC02: rd_val = lo_f(minstret_q);
      12'hB82, 12'hC82: rd_val = hi_f(minstret_q);
      default: impl = 1'b0;
    endcase
    for (int n = 0; n < NUM_HPM; n++) begin
      if (ex_csr_addr_i == 12'(12'hB03 + n)) begin
        impl = 1'b1;
`ifdef CSR_HPM_EN
        rd_val = lo_f(hpm_q[n]);
`endif
      end
      if (ex_csr_addr_i == 12'(12'hB83 + n)) begin
        impl = 1'b1;
`ifdef CSR_HPM_EN
        rd_val = hi_f(hpm_q[n]);
`endif
      end
    end
  end

  // RS/RC with a zero operand is a pure read and may target read-only space.
  assign wr_try = ex_csr_op_i == 2'b01 || (ex_csr_op_i[1] && ex_csr_wdata_i != '0);
  assign ex_csr_illegal_o = ex_csr_valid_i &&
    (!impl || (wr_try && (ex_csr_addr_i[11:10] == 2'b11 || ex_csr_addr_i == 12'h344)));
  assign ex_csr_rdata_o = ex_csr_illegal_o ? '0 : rd_val;
  assign we = ex_csr_valid_i && wr_try && !ex_csr_illegal_o;
  assign wval = ex_csr_op_i == 2'b01 ? ex_csr_wdata_i :
                ex_csr_op_i == 2'b10 ? rd_val | ex_csr_wdata_i : rd_val & ~ex_csr_wdata_i;

  always_comb begin
    mstatus_mie_d = trap_take_i ? 1'b0 : mret_i ? mstatus_mpie_q : ws(12'h300) ? wval[3] : mstatus_mie_q;
    mstatus_mpie_d = trap_take_i ? mstatus_mie_q : mret_i ? 1'b1 : ws(12'h300) ? wval[7] : mstatus_mpie_q;
    mie_d = ws(12'h304) ? {wval[11], wval[7], wval[3]} : mie_q;
    mtvec_d = ws(12'h305) ? wval : mtvec_q;
    mscratch_d = ws(12'h340) ? wval : mscratch_q;
    mepc_d = trap_take_i ? {trap_pc_i[XLEN-1:2], 2'b00} : ws(12'h341) ? {wval[XLEN-1:2], 2'b00} : mepc_q;
    mcause_d = trap_take_i ? trap_cause_i : ws(12'h342) ? wval : mcause_q;
    mip_d = {irq_ext_i, irq_tmr_i, irq_sw_i};
    cy_inh_d = ws(12'h320) ? wval[0] : cy_inh_q;
    ir_inh_d = ws(12'h320) ? wval[2] : ir_inh_q;
    mcycle_d = cnt_f(mcycle_q, !cy_inh_q, ws(12'hB00), ws(12'hB80), wval);
    minstret_d = cnt_f(minstret_q, instret_i && !ir_inh_q, ws(12'hB02), ws(12'hB82), wval);
`ifdef CSR_HPM_EN
    hpm_inh_d = ws(12'h320) ? wval[NUM_HPM+2:3] : hpm_inh_q;
    for (int n = 0; n < NUM_HPM; n++)
      hpm_d[n] = cnt_f(hpm_q[n], hpm_event_i[n] && !hpm_inh_q[n],
                       ws(12'(12'hB03 + n)), ws(12'(12'hB83 + n)), wval);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q <= '0;
      mip_q <= '0;
      mtvec_q <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      cy_inh_q <= 1'b0;
      ir_inh_q <= 1'b0;
      mcycle_q <= '0;
      minstret_q <= '0;
`ifdef CSR_HPM_EN
      hpm_inh_q <= '0;
      for (int n = 0; n < NUM_HPM; n++) hpm_q[n] <= '0;
`endif
    end else begin
      mstatus_mie_q <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q <= mie_d;
      mip_q <= mip_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      cy_inh_q <= cy_inh_d;
      ir_inh_q <= ir_inh_d;
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
`ifdef CSR_HPM_EN
      hpm_inh_q <= hpm_inh_d;
      for (int n = 0; n < NUM_HPM; n++) hpm_q[n] <= hpm_d[n];
`endif
    end
  end

  assign irq_pending_o = |(mip_q & mie_q) & mstatus_mie_q;
  assign global_irq_en_o = mstatus_mie_q;
  assign mepc_o = mepc_q;
  assign trap_vector_o = {mtvec_q[XLEN-1:2], 2'b00} +
    ((mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1]) ? XLEN'({trap_cause_i[4:0], 2'b00}) : '0);
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised machine-mode CSR file; successor to the fixed six-register CSR block.
- Adds atomic CSRRW/CSRRS/CSRRC read-modify-write, hardware trap entry/MRET sequencing, mip/mie interrupt pending logic, vectored mtvec, 64-bit counters with inhibit, and illegal-access flagging.
- Sits between execute stage (CSR instructions) and CLINT (trap control, interrupt sources).

Parameters:
- XLEN, 32, data width of all CSRs and data ports.
- CNT_W, 64, counter width; 33..64; upper half exposed at 0xB80/0xB82/0xC80/0xC82.
- NUM_HPM, 4, number of mhpmcounter3..(3+NUM_HPM-1); 1..29.
- MTVEC_RST, 0, reset value of mtvec.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_csr_valid_i  in  1  CSR instruction in execute this cycle
- ex_csr_op_i  in  2  01=RW, 10=RS, 11=RC, 00=read-only
- ex_csr_addr_i  in  12  CSR address
- ex_csr_wdata_i  in  XLEN  rs1/uimm operand
- ex_csr_rdata_o  out  XLEN  old CSR value (combinational)
- ex_csr_illegal_o  out  1  illegal access (combinational)
- instret_i  in  1  one instruction retired
- hpm_event_i  in  NUM_HPM  per-counter event pulse
- trap_take_i  in  1  CLINT commits trap entry
- trap_cause_i  in  XLEN  mcause value; bit XLEN-1 = interrupt
- trap_pc_i  in  XLEN  PC saved to mepc
- mret_i  in  1  MRET commits
- irq_ext_i / irq_tmr_i / irq_sw_i  in  1 each  level interrupt sources
- irq_pending_o  out  1  |(mip & mie) & mstatus.MIE
- trap_vector_o  out  XLEN  trap target PC
- mepc_o  out  XLEN  current mepc
- global_irq_en_o  out  1  mstatus.MIE

Behaviour:
- Reset (async, rst=1): all CSRs 0 except mtvec=MTVEC_RST; counters 0; mip 0. Outputs: irq_pending_o=0, global_irq_en_o=0, mepc_o=0, trap_vector_o=MTVEC_RST with low 2 bits cleared.
- Implemented addresses: 0x300 mstatus (MIE bit3, MPIE bit7 writable; MPP[12:11] reads 2'b11; others read 0), 0x304 mie (bits 3,7,11), 0x305 mtvec, 0x340 mscratch, 0x341 mepc (bits[1:0] read 0), 0x342 mcause, 0x344 mip (read-only), 0x320 mcountinhibit (bits 0,2,3..), 0xB00/0xB80 mcycle(h), 0xB02/0xB82 minstret(h), 0xB03+n/0xB83+n hpm, 0xC00/0xC80/0xC02/0xC82 read-only shadows.
- Read: ex_csr_rdata_o = current register value, same cycle; unimplemented → 0.
- Write value: RW=wdata; RS=old|wdata; RC=old&~wdata. Committed at next clk edge when valid and not illegal.
- Write suppression: RS/RC with wdata==0 performs no write and is never illegal on read-only addresses.
- Illegal: unimplemented address; or write attempt (RW, or RS/RC with wdata!=0) to addr[11:10]==2'b11 or to 0x344. Illegal → no state change; rdata=0.
- mip: registered each cycle from irq_ext_i(bit11), irq_tmr_i(bit7), irq_sw_i(bit3); one-cycle latency into irq_pending_o.
- Trap entry (trap_take_i): mepc<=trap_pc_i, mcause<=trap_cause_i, MPIE<=MIE, MIE<=0.
- MRET (mret_i): MIE<=MPIE, MPIE<=1.
- Priority same cycle: trap_take_i > mret_i > ex CSR write. The lower-priority write to the same register is dropped; writes to other registers still commit.
- trap_vector_o: mtvec[1:0]==01 and trap_cause_i[XLEN-1]=1 → {mtvec[XLEN-1:2],2'b00} + 4*trap_cause_i[4:0]; else {mtvec[XLEN-1:2],2'b00}. Combinational.
- Counters: mcycle +1 every cycle; minstret +1 on instret_i; hpm[n] +1 on hpm_event_i[n]; each gated by its mcountinhibit bit.
- Counter wrap: wrap at 2^CNT_W-1 → 0.
- Counter write: a CSR write to a counter half in the same cycle as an increment wins; the increment is lost. Half-writes leave the other half unchanged. Bits above CNT_W read 0.

Optional Feature:
- CSR_HPM_EN defined: hpm counters, hpm_event_i and mcountinhibit bits 3+ implemented.
- CSR_HPM_EN undefined: hpm addresses read 0, writes ignored (not illegal), hpm_event_i unused, no hpm flops.

Test Plan:
- Reset async mid-cycle with mstatus=0x88 → all CSRs 0, mtvec=MTVEC_RST immediately, before the next edge.
- RW 0x340 with 0xDEADBEEF, then RS 0x0000_00F0, then RC 0xDEAD_0000 → rdata 0, 0xDEADBEEF, 0xDEADBEFF; final mscratch 0x0000BEFF.
- mstatus=0x8, mie=0x80, irq_tmr_i=1 → irq_pending_o=1 one cycle later. trap_take_i cause 0x80000007, pc 0x100, mtvec=0x1001 → trap_vector_o=0x101C, mepc=0x100, mstatus=0x80 (plus MPP). mret_i → mstatus MIE=1.
- Same-cycle trap_take_i and RW 0x341 with 0x55 → mepc=trap_pc_i.
- mcycle preset 0xFFFFFFFF via 0xB00 write → next cycle mcycle=0x1_0000_0000 (mcycleh=1). Write to 0xC00 → illegal=1, no change. RS 0xC00 with wdata=0 → legal read.
- mcountinhibit=0x1 → mcycle holds for 10 cycles. Under CSR_HPM_EN: 3 pulses on hpm_event_i[0] → 0xB03 reads 3.
